// File: rtl/hpc1_and_pipelined.sv
// HPC1 masked AND gadget: D-th order, D+1 Boolean shares, WIDTH parallel bit-slices.
// Two register stages (refresh, then partial products) with valid/ready flow control.
module hpc1_and_pipelined #(
    parameter int D     = 1,
    parameter int WIDTH = 1,
    localparam int N    = D + 1,
    localparam int P    = (D * (D + 1)) / 2
) (
    input  logic                   clock_0,
    input  logic                   reset_0,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*WIDTH-1:0]     io_i0,
    input  logic [N*WIDTH-1:0]     io_i1,
    input  logic [2*P*WIDTH-1:0]   p_rand,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*WIDTH-1:0]     io_o0
);

    logic             s1_en_s;
    logic             s2_en_s;
    logic             acc_s;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] a_q [N];
    logic [WIDTH-1:0] a_d [N];
    logic [WIDTH-1:0] b_q [N];
    logic [WIDTH-1:0] b_d [N];
    logic [WIDTH-1:0] m_q [P];
    logic [WIDTH-1:0] m_d [P];
    logic [WIDTH-1:0] z_q [N][N];
    logic [WIDTH-1:0] z_d [N][N];
    logic [WIDTH-1:0] bref_s [N];
    logic [WIDTH-1:0] z_s [N][N];

    // Lexicographic index of share pair (i,j), i<j.
    function automatic int pidx(input int i, input int j);
        return i * N - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Handshake enables; in_ready depends only on stage occupancy and out_ready.
    always_comb begin
        s2_en_s   = !v2_q || out_ready;
        s1_en_s   = !v1_q || s2_en_s;
        acc_s     = in_valid && s1_en_s;
        in_ready  = s1_en_s;
        out_valid = v2_q;
    end

    // Refresh of operand b: each pair mask r_k lands on both shares of its pair.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bref_s[i] = io_i1[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                bref_s[i] = bref_s[i] ^ p_rand[pidx(i, j)*WIDTH +: WIDTH];
                bref_s[j] = bref_s[j] ^ p_rand[pidx(i, j)*WIDTH +: WIDTH];
            end
        end
    end

    // Stage-1 next state: capture shares and mult masks only on an accepted transfer.
    always_comb begin
        if (s1_en_s) begin
            v1_d = in_valid;
        end else begin
            v1_d = v1_q;
        end
        if (acc_s) begin
            for (int i = 0; i < N; i++) begin
                a_d[i] = io_i0[i*WIDTH +: WIDTH];
                b_d[i] = bref_s[i];
            end
            for (int k = 0; k < P; k++) begin
                m_d[k] = p_rand[(P+k)*WIDTH +: WIDTH];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_d[i] = a_q[i];
                b_d[i] = b_q[i];
            end
            for (int k = 0; k < P; k++) begin
                m_d[k] = m_q[k];
            end
        end
    end

    // Cross-share partial products; each off-diagonal term is masked by its pair's m_k.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i == j) begin
                    z_s[i][j] = a_q[i] & b_q[j];
                end else if (i < j) begin
                    z_s[i][j] = (a_q[i] & b_q[j]) ^ m_q[pidx(i, j)];
                end else begin
                    z_s[i][j] = (a_q[i] & b_q[j]) ^ m_q[pidx(j, i)];
                end
            end
        end
    end

    // Stage-2 next state: advance only when stage 2 is free and stage 1 holds data.
    always_comb begin
        if (s2_en_s) begin
            v2_d = v1_q;
        end else begin
            v2_d = v2_q;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (s2_en_s && v1_q) begin
                    z_d[i][j] = z_s[i][j];
                end else begin
                    z_d[i][j] = z_q[i][j];
                end
            end
        end
    end

    // Pipeline registers with synchronous clear.
    always_ff @(posedge clock_0) begin
        if (reset_0) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    z_q[i][j] <= '0;
                end
            end
            for (int k = 0; k < P; k++) begin
                m_q[k] <= '0;
            end
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                for (int j = 0; j < N; j++) begin
                    z_q[i][j] <= z_d[i][j];
                end
            end
            for (int k = 0; k < P; k++) begin
                m_q[k] <= m_d[k];
            end
        end
    end

    // Output share i is the XOR of row i of the stage-2 registers; nothing else on this path.
    always_comb begin
        io_o0 = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                io_o0[i*WIDTH +: WIDTH] = io_o0[i*WIDTH +: WIDTH] ^ z_q[i][j];
            end
        end
    end

endmodule

// File: tb/tb_hpc1_and_pipelined.sv
// Randomized bench for hpc1_and_pipelined (D=2, WIDTH=8): unmasked result model plus
// directed latency, stall and mid-flight reset scenarios.
module tb_hpc1_and_pipelined;

    localparam int D  = 2;
    localparam int W  = 8;
    localparam int N  = D + 1;
    localparam int P  = (D * (D + 1)) / 2;
    localparam int NW = N * W;
    localparam int PW = 2 * P * W;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [NW-1:0] a_in = '0;
    logic [NW-1:0] b_in = '0;
    logic [PW-1:0] r_in = '0;
    logic [NW-1:0] o;
    logic [NW-1:0] hold;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    logic [W-1:0] exp_q [$];

    hpc1_and_pipelined #(.D(D), .WIDTH(W)) dut (
        .clock_0   (clk),
        .reset_0   (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .io_i0     (a_in),
        .io_i1     (b_in),
        .p_rand    (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .io_o0     (o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] recomb(input logic [NW-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r = r ^ v[i*W +: W];
        end
        return r;
    endfunction

    task automatic rand_inputs();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        a_in = t[NW-1:0];
        t = {$urandom(), $urandom()};
        b_in = t[NW-1:0];
        t = {$urandom(), $urandom()};
        r_in = t[PW-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            tick();
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: samples handshakes mid-cycle, model is the plain unmasked AND.
    always @(negedge clk) begin
        if (rst) begin
            n_in = n_in - exp_q.size();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 1, 0);
                end else begin
                    check_eq("result", recomb(o), exp_q.pop_front());
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(recomb(a_in) & recomb(b_in));
                n_in++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        logic [W-1:0] dir_exp [2];

        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_io_o0", o, 0);
        check_eq("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Directed: recombined a=0x33,b=0xFF -> 0x33; a=0x00 -> 0x00.
        dir_exp[0] = 8'h33;
        dir_exp[1] = 8'h00;
        for (int v = 0; v < 2; v++) begin
            rand_inputs();
            a_in = (v == 0) ? 24'h000F3C : 24'h0F0F00;
            b_in = 24'h0055AA;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check_eq("lat_cycle1", out_valid, 0);
            tick();
            check_eq("lat_cycle2", out_valid, 1);
            check_eq("directed", recomb(o), dir_exp[v]);
            tick();
        end

        // Back-to-back stream, one result per cycle.
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            check_eq("stream_in_ready", in_ready, 1);
            if (i >= 2) begin
                check_eq("stream_out_valid", out_valid, 1);
            end
            rand_inputs();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();
        check_eq("stream_count", n_out - base, 300);

        // Random handshakes on both sides.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Stall: fill with out_ready low, output must stay bit-exact.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        rand_inputs();
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        hold = o;
        for (int i = 0; i < 5; i++) begin
            tick();
            rand_inputs();
            check_eq("stall_hold", o, hold);
            check_eq("stall_in_ready_hold", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with two items in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_io_o0", o, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        rand_inputs();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("post_rst_lat1", out_valid, 0);
        tick();
        check_eq("post_rst_lat2", out_valid, 1);
        drain();
        tick();
        check_eq("final_idle", out_valid, 0);
        check_eq("in_out_count", n_out, n_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
